io_bus_controller: RTL and testbench
====================================

# io_bus_controller

Parametrised memory-mapped I/O and SRAM bus controller between the CPU data port and the board. The top addresses of the CPU space decode to NOUT registered output ports (LEDs, displays) and NIN synchronised input ports (switches, keys). All other addresses go to external asynchronous SRAM through a registered access state machine with configurable wait states and a `ready` handshake back to the CPU.

## Interface
- `AW`, 16: CPU address width.
- `SRAM_AW`, 18: SRAM address width, at least `AW`.
- `PW`, 8: width of each I/O port, 1..16.
- `NOUT`, 2: number of output ports, at least 1.
- `NIN`, 1: number of input ports, at least 0.
- `WAIT_STATES`, 1: extra SRAM strobe cycles, at least 0.
- `OUT_INV`, 1: when 1, output pins show the bitwise inverse of the stored value (active-low LEDs).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `addr` in AW: CPU address.
- `wdata` in 16: CPU write data.
- `we` in 1: write request. Held until `ready`.
- `re` in 1: read request. Held until `ready`.
- `rdata` out 16: read data, valid while `ready` is high.
- `ready` out 1: one-cycle completion pulse.
- `out_port` out NOUT*PW: port k occupies bits [k*PW +: PW].
- `in_port` in NIN*PW: asynchronous inputs, same packing as `out_port`.
- `sram_addr` out SRAM_AW: SRAM address.
- `sram_dq` inout 16: SRAM data bus.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` out 1 each: SRAM strobes.

## Operation
- **Address decode.** Let k = all-ones(AW) − `addr`.
  - k < NOUT: output register k.
  - NOUT ≤ k < NOUT+NIN: input port k−NOUT.
  - Anything else: SRAM.
- **Request priority.** A request is `we` or `re`. If both are high, the access is a write.
- **State machine: IDLE, ACCESS, DONE.**
  - IDLE with a request:
    - I/O target: the access is performed and the state goes to DONE.
    - SRAM target: `addr` zero-extended is latched into `sram_addr`, and `wdata` is latched for writes. The state goes to ACCESS and the wait counter loads WAIT_STATES.
  - ACCESS: the counter decrements each cycle. When the counter is 0, the state goes to DONE.
  - DONE: `ready` is 1 and the state returns to IDLE.
- **CPU handshake.** The CPU deasserts its request in the DONE cycle. A request still high in the following IDLE cycle is treated as a new access.
- **I/O write.** Output register k takes `wdata[PW-1:0]`.
- **I/O read.**
  - Input port: `rdata` = zero-extended value from the two-flop synchroniser.
  - Output register: `rdata` = zero-extended stored value (not inverted).
- **SRAM read.** During ACCESS, `sram_ce_n` and `sram_oe_n` are 0 and `sram_dq` is Z. `rdata` captures `sram_dq` on the last ACCESS edge.
- **SRAM write.** During ACCESS, `sram_ce_n` and `sram_we_n` are 0 and `sram_dq` is driven with the latched data. In DONE, `sram_we_n` is 1 and `sram_dq` is still driven (one cycle of data hold). `sram_dq` is Z in every other state.
- **Byte lanes.** `sram_ub_n` and `sram_lb_n` are 0 whenever `sram_ce_n` is 0, and 1 otherwise.
- **Output pins.** `out_port` = stored value XOR {PW{OUT_INV}}.
- **I/O write data.** The SRAM bus is not touched for I/O accesses.

## Timing
- **Reset (asynchronous, takes effect immediately, including mid-access):**
  - State goes to IDLE.
  - `ready`=0 and `rdata`=0.
  - `sram_addr`=0.
  - All SRAM strobes = 1 and `sram_dq` = Z.
  - Output registers = 0, so pins are all ones when OUT_INV=1.
  - Synchroniser flops = 0.
- All outputs are registered. No combinational path from CPU inputs to outputs.
- **Latency, request seen in IDLE at edge E0:**
  - I/O access: `ready` is high in the cycle after E0.
  - SRAM access: ACCESS lasts WAIT_STATES+1 cycles, and `ready` is high in cycle WAIT_STATES+2 after E0.
- **Input ports.** An input change is visible to reads after two to three clock edges.
- Requests arriving in ACCESS or DONE are not accepted mid-access.
- **Address range.** SRAM addresses that alias the I/O window are unreachable.

## Test plan
- **Reset.** Assert `reset` mid-SRAM-write.
  - Same cycle: `sram_we_n`=1, `sram_dq`=Z, `ready`=0.
  - `out_port` = all ones (OUT_INV=1).
- **I/O write and readback.** With defaults, write 0x00A5 to 0xFFFF, then read 0xFFFF.
  - `ready` one cycle after each request.
  - `out_port[7:0]` = 0x5A.
  - Read returns `rdata` = 0x00A5.
- **Input synchronisation.** Set `in_port` = 0x3C, wait 3 cycles, read 0xFFFD → `rdata` = 0x003C.
- **SRAM write.** WAIT_STATES=1, write 0x1234 to 0x0010.
  - `sram_addr` = 0x00010.
  - `sram_we_n` low for exactly 2 cycles.
  - `sram_dq` = 0x1234 for 3 cycles.
  - `ready` in cycle 3.
- **SRAM read.** Bench model drives 0xBEEF on a read of 0x0020 → `rdata` = 0xBEEF with `ready`. Repeat with WAIT_STATES=0 → `ready` in cycle 2.
- **Priority and back-to-back.** `we` and `re` both high to 0xFFFE → performed as a write. Next, keep `re` high through DONE → a second read starts in the following IDLE.

Source files
------------

// File: rtl/io_bus_controller.sv
// CPU data-port bus controller: top-of-space addresses hit registered output ports and
// synchronised input ports, everything else runs a wait-stated access on asynchronous SRAM.
module io_bus_controller #(
    parameter int unsigned AW          = 16,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned PW          = 8,
    parameter int unsigned NOUT        = 2,
    parameter int unsigned NIN         = 1,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned OUT_INV     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [AW-1:0]                    addr,
    input  logic [15:0]                      wdata,
    input  logic                             we,
    input  logic                             re,
    output logic [15:0]                      rdata,
    output logic                             ready,
    output logic [NOUT*PW-1:0]               out_port,
    input  logic [((NIN > 0) ? NIN : 1)*PW-1:0] in_port,
    output logic [SRAM_AW-1:0]               sram_addr,
    inout  wire  [15:0]                      sram_dq,
    output logic                             sram_ce_n,
    output logic                             sram_oe_n,
    output logic                             sram_we_n,
    output logic                             sram_ub_n,
    output logic                             sram_lb_n
);

    localparam int unsigned InW = ((NIN > 0) ? NIN : 1) * PW;
    localparam int unsigned CW  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [PW-1:0] InvMask = (OUT_INV != 0) ? {PW{1'b1}} : {PW{1'b0}};

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      out_q [NOUT];
    logic [PW-1:0]      out_d [NOUT];
    logic [InW-1:0]     sync1_q, sync2_q;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic               is_write_q, is_write_d;
    logic               ready_q, ready_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               dq_oe_q, dq_oe_d;

    // k counts down from the top of the address space.
    logic [AW-1:0] k;
    logic          is_io;
    logic          req;
    logic [15:0]   io_rdata;

    assign k     = ~addr;
    assign is_io = (k < AW'(NOUT + NIN));
    assign req   = we | re;

    always_comb begin
        io_rdata = '0;
        for (int unsigned i = 0; i < NOUT; i++) begin
            if (k == AW'(i)) io_rdata = 16'(out_q[i]);
        end
        for (int unsigned j = 0; j < NIN; j++) begin
            if (k == AW'(NOUT + j)) io_rdata = 16'(sync2_q[j*PW +: PW]);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        is_write_d  = is_write_q;
        ready_d     = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        dq_oe_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (is_io) begin
                        state_d = StDone;
                        ready_d = 1'b1;
                        if (we) begin
                            for (int unsigned i = 0; i < NOUT; i++) begin
                                if (k == AW'(i)) out_d[i] = wdata[PW-1:0];
                            end
                        end else begin
                            rdata_d = io_rdata;
                        end
                    end else begin
                        state_d     = StAccess;
                        cnt_d       = CW'(WAIT_STATES);
                        sram_addr_d = SRAM_AW'(addr);
                        is_write_d  = we;
                        if (we) wdata_d = wdata;
                        ce_n_d  = 1'b0;
                        oe_n_d  = we;
                        we_n_d  = ~we;
                        dq_oe_d = we;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    ready_d = 1'b1;
                    // Write data is held one extra cycle after the we_n rising edge.
                    dq_oe_d = is_write_q;
                    if (!is_write_q) rdata_d = sram_dq;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    ce_n_d  = 1'b0;
                    oe_n_d  = is_write_q;
                    we_n_d  = ~is_write_q;
                    dq_oe_d = is_write_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            out_q       <= '{default: '0};
            sync1_q     <= '0;
            sync2_q     <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            is_write_q  <= 1'b0;
            ready_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            sync1_q     <= in_port;
            sync2_q     <= sync1_q;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            is_write_q  <= is_write_d;
            ready_q     <= ready_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign rdata     = rdata_q;
    assign ready     = ready_q;
    assign sram_addr = sram_addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_ub_n = ce_n_q;
    assign sram_lb_n = ce_n_q;
    assign sram_dq   = dq_oe_q ? wdata_q : 16'hzzzz;

    for (genvar g = 0; g < NOUT; g++) begin : g_out
        assign out_port[g*PW +: PW] = out_q[g] ^ InvMask;
    end

endmodule

// File: tb/tb_io_bus_controller.sv
// Randomised bench for io_bus_controller: two instances (one and zero wait states) against a
// transaction-level model of the ports and SRAM contents, plus directed boundary cases.
module tb_io_bus_controller;

    localparam int unsigned WS0 = 1;
    localparam int unsigned WS1 = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic        we    [2];
    logic        re    [2];
    logic [7:0]  in_port;
    logic [15:0] rdata [2];
    logic        ready [2];
    logic [15:0] out_port [2];
    logic [17:0] sram_addr [2];
    logic        ce_n [2];
    logic        oe_n [2];
    logic        we_n [2];
    logic        ub_n [2];
    logic        lb_n [2];
    wire  [15:0] dq0;
    wire  [15:0] dq1;

    // SRAM device models; probe forces a known word to show the controller has released the bus.
    logic        probe [2];
    logic        dev_load;
    logic [15:0] seed_base;
    logic [15:0] dev0 [64];
    logic [15:0] dev1 [64];
    logic        dev_en0, dev_en1;
    logic [15:0] dev_val0, dev_val1;

    // Reference model.
    logic [7:0]  m_out  [2][2];
    logic [15:0] shadow [2][64];

    int n_checks = 0;
    int n_errors = 0;

    io_bus_controller #(.WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .reset(reset), .addr(addr[0]), .wdata(wdata[0]), .we(we[0]), .re(re[0]),
        .rdata(rdata[0]), .ready(ready[0]), .out_port(out_port[0]), .in_port(in_port),
        .sram_addr(sram_addr[0]), .sram_dq(dq0), .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]),
        .sram_we_n(we_n[0]), .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0])
    );

    io_bus_controller #(.WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .reset(reset), .addr(addr[1]), .wdata(wdata[1]), .we(we[1]), .re(re[1]),
        .rdata(rdata[1]), .ready(ready[1]), .out_port(out_port[1]), .in_port(in_port),
        .sram_addr(sram_addr[1]), .sram_dq(dq1), .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]),
        .sram_we_n(we_n[1]), .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1])
    );

    function automatic logic [15:0] seed_word(input int u, input int i);
        if (i == 32) return 16'hBEEF;
        return seed_base ^ 16'(i * 40503 + u * 977);
    endfunction

    always_comb begin
        dev_en0  = probe[0] || (!ce_n[0] && !oe_n[0]);
        dev_val0 = probe[0] ? 16'h5AA5 : dev0[sram_addr[0][5:0]];
        dev_en1  = probe[1] || (!ce_n[1] && !oe_n[1]);
        dev_val1 = probe[1] ? 16'h5AA5 : dev1[sram_addr[1][5:0]];
    end

    assign dq0 = dev_en0 ? dev_val0 : 16'hzzzz;
    assign dq1 = dev_en1 ? dev_val1 : 16'hzzzz;

    always @(posedge clk) begin
        if (dev_load) begin
            for (int i = 0; i < 64; i++) begin
                dev0[i] <= seed_word(0, i);
                dev1[i] <= seed_word(1, i);
            end
        end else begin
            if (!ce_n[0] && !we_n[0]) dev0[sram_addr[0][5:0]] <= dq0;
            if (!ce_n[1] && !we_n[1]) dev1[sram_addr[1][5:0]] <= dq1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_z(input int u, input string tag);
        probe[u] = 1'b1;
        #1;
        check_eq(tag, 32'((u == 0) ? dq0 : dq1), 32'h5AA5);
        probe[u] = 1'b0;
    endtask

    task automatic check_reset_state(input int u, input string tag);
        check_eq({tag, "_ready"}, 32'(ready[u]), 32'd0);
        check_eq({tag, "_rdata"}, 32'(rdata[u]), 32'd0);
        check_eq({tag, "_pins"}, 32'(out_port[u]), 32'hFFFF);
        check_eq({tag, "_sram_addr"}, 32'(sram_addr[u]), 32'd0);
        check_eq({tag, "_strobes"}, 32'({ce_n[u], oe_n[u], we_n[u], ub_n[u], lb_n[u]}), 32'h1F);
    endtask

    // One CPU transaction; the model predicts latency, strobe activity and read data.
    task automatic xact(input int u, input bit w, input bit r, input logic [15:0] a,
                        input logic [15:0] d, input bit hold);
        int ws, k, lat, acc, ce_lo, oe_lo, we_lo, lane_lo, dq_hits;
        bit io;
        logic [15:0] got, exp_rd;
        ws = (u == 0) ? int'(WS0) : int'(WS1);
        k  = int'(16'hFFFF - a);
        io = (k < 3);
        lat = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; lane_lo = 0; dq_hits = 0; got = '0;
        @(negedge clk);
        addr[u] = a; wdata[u] = d; we[u] = w; re[u] = r;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 && !io) check_eq("sram_addr", 32'(sram_addr[u]), 32'(a));
            if (!ce_n[u]) ce_lo++;
            if (!oe_n[u]) oe_lo++;
            if (!we_n[u]) we_lo++;
            if (!ub_n[u] && !lb_n[u]) lane_lo++;
            if (((u == 0) ? dq0 : dq1) === d) dq_hits++;
            if (ready[u]) begin
                lat = c;
                got = rdata[u];
                break;
            end
        end
        if (!hold) begin
            we[u] = 1'b0;
            re[u] = 1'b0;
        end
        acc = io ? 0 : ws + 1;
        check_eq("latency", lat, io ? 1 : ws + 2);
        check_eq("ce_cycles", ce_lo, acc);
        check_eq("lane_cycles", lane_lo, acc);
        check_eq("oe_cycles", oe_lo, w ? 0 : acc);
        check_eq("we_cycles", we_lo, w ? acc : 0);
        if (w && !io) check_eq("dq_drive_cycles", dq_hits, ws + 2);
        if (w) begin
            if (io) begin
                if (k < 2) m_out[u][k] = d[7:0];
            end else begin
                shadow[u][a[5:0]] = d;
            end
        end else begin
            if (!io) exp_rd = shadow[u][a[5:0]];
            else if (k < 2) exp_rd = {8'h00, m_out[u][k]};
            else exp_rd = {8'h00, in_port};
            check_eq("rdata", 32'(got), 32'(exp_rd));
        end
        if (io) check_eq("out_port", 32'(out_port[u]), 32'({~m_out[u][1], ~m_out[u][0]}));
        if (!hold) begin
            @(posedge clk);
            #1;
            if (w && !io) check_z(u, "dq_release");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        seed_base = 16'($urandom);
        for (int u = 0; u < 2; u++) begin
            addr[u] = '0; wdata[u] = '0; we[u] = 1'b0; re[u] = 1'b0; probe[u] = 1'b0;
            m_out[u][0] = '0; m_out[u][1] = '0;
            for (int i = 0; i < 64; i++) shadow[u][i] = seed_word(u, i);
        end
        in_port  = 8'h00;
        reset    = 1'b1;
        dev_load = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state(0, "rst0");
        check_reset_state(1, "rst1");
        check_z(0, "rst_dq");
        @(negedge clk);
        reset    = 1'b0;
        dev_load = 1'b0;

        // Output port write, pins, readback.
        xact(0, 1'b1, 1'b0, 16'hFFFF, 16'h00A5, 1'b0);
        check_eq("led_pins", 32'(out_port[0][7:0]), 32'h5A);
        xact(0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);

        // Input synchroniser.
        @(negedge clk);
        in_port = 8'h3C;
        repeat (3) @(posedge clk);
        xact(0, 1'b0, 1'b1, 16'hFFFD, 16'h0000, 1'b0);

        // SRAM write, readback, model-driven read on both wait-state settings.
        xact(0, 1'b1, 1'b0, 16'h0010, 16'h1234, 1'b0);
        xact(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0);
        xact(0, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0);
        xact(1, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0);

        // Write wins when both requests are high.
        xact(0, 1'b1, 1'b1, 16'hFFFE, 16'h0077, 1'b0);
        check_eq("prio_pins", 32'(out_port[0][15:8]), 32'h88);
        xact(0, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 1'b0);

        // Read held through DONE starts a second access from the next idle cycle.
        xact(0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        @(posedge clk);
        #1;
        check_eq("b2b_idle_ready", 32'(ready[0]), 32'd0);
        @(posedge clk);
        #1;
        check_eq("b2b_ready", 32'(ready[0]), 32'd1);
        check_eq("b2b_rdata", 32'(rdata[0]), 32'({8'h00, m_out[0][0]}));
        re[0] = 1'b0;
        @(posedge clk);

        for (int n = 0; n < 80; n++) begin
            int u, sel;
            bit w, r;
            logic [15:0] a;
            u   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 6));
            a   = (sel < 3) ? 16'hFFFF - 16'(sel) : 16'($urandom_range(0, 63));
            w   = 1'($urandom_range(0, 1));
            r   = !w || ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                in_port = 8'($urandom);
                repeat (3) @(posedge clk);
            end
            xact(u, w, r, a, 16'($urandom), 1'b0);
        end

        // Asynchronous reset in the middle of an SRAM write.
        @(negedge clk);
        addr[0]  = 16'h0030;
        wdata[0] = 16'h4321;
        we[0]    = 1'b1;
        @(posedge clk);
        #2;
        check_eq("mid_we_low", 32'(we_n[0]), 32'd0);
        reset = 1'b1;
        #1;
        check_reset_state(0, "midrst");
        check_z(0, "midrst_dq");
        we[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            m_out[u][0] = '0;
            m_out[u][1] = '0;
        end
        xact(0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
